poly_voice_engine: RTL and testbench

- N-voice successor to the monophonic note-on/off/pitch-bend phase-accumulator path in the synth top level.
- Consumes decoded MIDI words from the mmio MIDI receiver. Allocates voices with retrigger and oldest-voice stealing.
- Applies global pitch bend and advances one phase accumulator per voice on each sample strobe.
- Per-voice phase indices drive the existing waveform LUTs; the downstream mixer sums them.

---
 rtl/poly_voice_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_poly_voice_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: MIDI note/bend decode, voice allocation with retrigger and
// oldest-voice stealing, and one bent phase accumulator per voice advanced on sample_tick.
module poly_voice_engine #(
  parameter int VOICES     = 4,
  parameter int ACC_W      = 32,
  parameter int NOTE_BASE  = 21,
  parameter int NOTES      = 96,
  parameter int BEND_SHIFT = 4,
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  midi_valid,
  output logic                  midi_ready,
  input  logic [23:0]           midi_word,
  input  logic                  sample_tick,
  input  logic                  inc_wr_en,
  input  logic [6:0]            inc_wr_addr,
  input  logic [ACC_W-1:0]      inc_wr_data,
  output logic [VOICES*16-1:0]  phase_bus,
  output logic [VOICES*7-1:0]   velocity_bus,
  output logic [VOICES-1:0]     active_mask
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, APPLY, BEND} state_t;

  localparam int         IW       = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [7:0] NOTE_LO  = 8'(NOTE_BASE);
  localparam logic [7:0] NOTE_HI  = 8'(NOTE_BASE + NOTES - 1);
  localparam logic [6:0] ADDR_TOP = 7'(NOTES - 1);

  logic [ACC_W-1:0] r_table [NOTES];
  logic [ACC_W-1:0] r_rd_data;

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic signed [7:0] r_bend;
  logic [7:0]        r_note;
  logic [6:0]        r_vel;
  logic [6:0]        r_addr;
  logic [ACC_W-1:0]  r_base, r_delta;

  logic [7:0]        r_vnote  [VOICES];
  logic [6:0]        r_vvel   [VOICES];
  logic [ACC_W-1:0]  r_vbase  [VOICES];
  logic [ACC_W-1:0]  r_vdelta [VOICES];
  logic [ACC_W-1:0]  r_vbent  [VOICES];
  logic [ACC_W-1:0]  r_vphase [VOICES];
  logic [7:0]        r_vage   [VOICES];
  logic [VOICES-1:0] r_active;

  logic [3:0] w_status, w_chan;
  logic [7:0] w_data1, w_data2;
  logic       w_accept, w_chan_ok, w_in_range, w_note_on, w_note_off, w_bend_msg;
  logic [6:0] w_base_addr, w_rd_addr;

  assign w_status    = midi_word[23:20];
  assign w_chan      = midi_word[19:16];
  assign w_data1     = midi_word[15:8];
  assign w_data2     = midi_word[7:0];
  assign w_accept    = midi_valid && (r_state == IDLE);
  assign w_chan_ok   = (OMNI != 0) || (w_chan == 4'(CHANNEL));
  assign w_in_range  = (w_data1 >= NOTE_LO) && (w_data1 <= NOTE_HI);
  assign w_note_on   = w_accept && w_chan_ok && (w_status == 4'h9) && (w_data2 != 8'd0) && w_in_range;
  assign w_note_off  = w_accept && w_chan_ok &&
                       ((w_status == 4'h8) || ((w_status == 4'h9) && (w_data2 == 8'd0)));
  assign w_bend_msg  = w_accept && w_chan_ok && (w_status == 4'hE);
  assign w_base_addr = 7'(w_data1 - NOTE_LO);

  // The top note has no upper neighbour, so its bend span is taken from the note below.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_rd_addr = w_base_addr;
    if (r_state == RD0) w_rd_addr = (r_addr == ADDR_TOP) ? r_addr - 7'd1 : r_addr + 7'd1;
  end

  // NOTE: the increment table is RAM and has no reset; its contents survive resetn.
  always_ff @(posedge clock) begin
    if (inc_wr_en && (inc_wr_addr <= ADDR_TOP)) r_table[inc_wr_addr] <= inc_wr_data;
    r_rd_data <= r_table[w_rd_addr];
  end

  logic [ACC_W-1:0]        w_mul_base, w_mul_delta, w_bend_off, w_bent, w_abs;
  logic signed [ACC_W+8:0] w_bend_x, w_delta_x, w_prod;

  always_comb begin
    w_mul_base  = r_base;
    w_mul_delta = r_delta;
    if (r_state == BEND) begin
      w_mul_base  = r_vbase[r_idx];
      w_mul_delta = r_vdelta[r_idx];
    end
  end

  assign w_bend_x   = {{(ACC_W+1){r_bend[7]}}, r_bend};
  assign w_delta_x  = {9'd0, w_mul_delta};
  assign w_prod     = w_bend_x * w_delta_x;
  assign w_bend_off = ACC_W'(w_prod >>> BEND_SHIFT);
  assign w_bent     = w_mul_base + w_bend_off;
  assign w_abs      = (r_rd_data >= r_base) ? r_rd_data - r_base : r_base - r_rd_data;

  logic          w_hit, w_free;
  logic [IW-1:0] w_hit_idx, w_free_idx, w_old_idx, w_sel;
  logic [7:0]    w_old_age;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_old_idx  = '0;
    w_old_age  = r_vage[0];
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_vnote[i] == r_note)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (!r_active[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
    end
    for (int i = 1; i < VOICES; i++) begin
      if (r_vage[i] > w_old_age) begin
        w_old_age = r_vage[i];
        w_old_idx = IW'(i);
      end
    end
    w_sel = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_old_idx);
  end

  // NOTE: all sequential state uses non-blocking assignment; later writes in this block override the phase advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_bend   <= '0;
      r_note   <= '0;
      r_vel    <= '0;
      r_addr   <= '0;
      r_base   <= '0;
      r_delta  <= '0;
      r_active <= '0;
      for (int i = 0; i < VOICES; i++) begin
        r_vnote[i]  <= '0;
        r_vvel[i]   <= '0;
        r_vbase[i]  <= '0;
        r_vdelta[i] <= '0;
        r_vbent[i]  <= '0;
        r_vphase[i] <= '0;
        r_vage[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++)
        if (sample_tick && r_active[i]) r_vphase[i] <= r_vphase[i] + r_vbent[i];

      case (r_state)
        IDLE: begin
          if (w_note_on) begin
            r_note  <= w_data1;
            r_vel   <= w_data2[6:0];
            r_addr  <= w_base_addr;
            r_state <= RD0;
          end else if (w_note_off) begin
            for (int i = 0; i < VOICES; i++)
              if (r_active[i] && (r_vnote[i] == w_data1)) begin
                r_active[i] <= 1'b0;
                r_vphase[i] <= '0;
              end
          end else if (w_bend_msg) begin
            r_bend  <= {1'b0, w_data2[6:0]} - 8'd64;
            r_idx   <= '0;
            r_state <= BEND;
          end
        end
        RD0: begin
          r_base  <= r_rd_data;
          r_state <= RD1;
        end
        RD1: begin
          r_delta <= w_abs;
          r_state <= APPLY;
        end
        APPLY: begin
          for (int i = 0; i < VOICES; i++) begin
            if (IW'(i) == w_sel) begin
              r_vnote[i]  <= r_note;
              r_vvel[i]   <= r_vel;
              r_vbase[i]  <= r_base;
              r_vdelta[i] <= r_delta;
              r_vbent[i]  <= w_bent;
              r_vphase[i] <= '0;
              r_vage[i]   <= '0;
              r_active[i] <= 1'b1;
            end else if (r_vage[i] != 8'hFF) begin
              r_vage[i] <= r_vage[i] + 8'd1;
            end
          end
          r_state <= IDLE;
        end
        BEND: begin
          r_vbent[r_idx] <= w_bent;
          if (r_idx == IW'(VOICES - 1)) r_state <= IDLE;
          else                          r_idx   <= r_idx + IW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    phase_bus    = '0;
    velocity_bus = '0;
    for (int i = 0; i < VOICES; i++) begin
      phase_bus[16*i +: 16]   = r_vphase[i][ACC_W-1 -: 16];
      velocity_bus[7*i +: 7]  = r_vvel[i];
    end
  end

  assign active_mask = r_active;
  assign midi_ready  = (r_state == IDLE);

endmodule

// File: tb/tb_poly_voice_engine.sv
// Scoreboard bench for poly_voice_engine: stimulus queues expected values, a monitor
// process pops and compares them against the DUT outputs on each falling clock edge.
`timescale 1ns/1ps
module tb_poly_voice_engine;

  localparam int VOICES = 4;
  localparam int ACC_W  = 32;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic                 midi_valid = 1'b0;
  logic                 midi_ready;
  logic [23:0]          midi_word = '0;
  logic                 sample_tick = 1'b0;
  logic                 inc_wr_en = 1'b0;
  logic [6:0]           inc_wr_addr = '0;
  logic [ACC_W-1:0]     inc_wr_data = '0;
  logic [VOICES*16-1:0] phase_bus;
  logic [VOICES*7-1:0]  velocity_bus;
  logic [VOICES-1:0]    active_mask;

  always #5 clock = ~clock;

  poly_voice_engine #(
    .VOICES(VOICES), .ACC_W(ACC_W), .NOTE_BASE(21), .NOTES(96),
    .BEND_SHIFT(4), .CHANNEL(0), .OMNI(0)
  ) dut (
    .clock(clock), .resetn(resetn),
    .midi_valid(midi_valid), .midi_ready(midi_ready), .midi_word(midi_word),
    .sample_tick(sample_tick),
    .inc_wr_en(inc_wr_en), .inc_wr_addr(inc_wr_addr), .inc_wr_data(inc_wr_data),
    .phase_bus(phase_bus), .velocity_bus(velocity_bus), .active_mask(active_mask)
  );

  typedef enum int {K_MASK, K_PH, K_VEL, K_READY, K_LAT, K_PBUS, K_VBUS} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          idx;
    logic [63:0] exp;
    logic [63:0] act;
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic push(input string name, input kind_t kind, input int idx,
                      input logic [63:0] exp, input logic [63:0] act = '0);
    item_t it;
    it.name = name; it.kind = kind; it.idx = idx; it.exp = exp; it.act = act;
    sb.push_back(it);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    item_t       it;
    logic [63:0] a;
    forever begin
      @(negedge clock);
      #1;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_MASK:  a = 64'(active_mask);
          K_PH:    a = 64'(phase_bus[16*it.idx +: 16]);
          K_VEL:   a = 64'(velocity_bus[7*it.idx +: 7]);
          K_READY: a = 64'(midi_ready);
          K_PBUS:  a = 64'(phase_bus);
          K_VBUS:  a = 64'(velocity_bus);
          default: a = it.act;
        endcase
        n_vec++;
        if (a !== it.exp) begin
          n_err++;
          $display("FAIL %s: actual 0x%0h expected 0x%0h", it.name, a, it.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model pieces: table contents, bent increment, top 16 phase bits.
  function automatic longint inc_of(input int note);
    return 64'(1000 * (note - 21 + 1));
  endfunction

  function automatic longint bent_of(input int note, input int bend);
    longint base, nb, delta;
    base  = inc_of(note);
    nb    = (note == 116) ? inc_of(note - 1) : inc_of(note + 1);
    delta = (nb > base) ? nb - base : base - nb;
    return (base + ((longint'(bend) * delta) >>> 4)) & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] top16(input longint total);
    return 64'((total & 64'hFFFF_FFFF) >> 16);
  endfunction

  task automatic send(input logic [23:0] w, output int lat);
    midi_word  = w;
    midi_valid = 1'b1;
    @(negedge clock);
    midi_valid = 1'b0;
    lat = 0;
    while (!midi_ready && lat < 40) begin
      lat++;
      @(negedge clock);
    end
  endtask

  task automatic msg(input string nm, input logic [23:0] w, input int exp_lat);
    int lat;
    send(w, lat);
    push({nm, " ready-low cycles"}, K_LAT, 0, 64'(exp_lat), 64'(lat));
  endtask

  task automatic ticks(input int n);
    sample_tick = 1'b1;
    repeat (n) @(negedge clock);
    sample_tick = 1'b0;
  endtask

  initial begin
    longint b1, b2;

    @(negedge clock);
    push("reset mask", K_MASK, 0, 64'h0);
    push("reset phase_bus", K_PBUS, 0, 64'h0);
    push("reset velocity_bus", K_VBUS, 0, 64'h0);
    push("reset ready", K_READY, 0, 64'h1);
    #2 resetn = 1'b1;
    @(negedge clock);

    inc_wr_en = 1'b1;
    for (int k = 0; k < 96; k++) begin
      inc_wr_addr = 7'(k);
      inc_wr_data = 32'(1000 * (k + 1));
      @(negedge clock);
    end
    inc_wr_en = 1'b0;

    // First note-on and three sample ticks.
    msg("note60", 24'h903C64, 3);
    push("note60 mask", K_MASK, 0, 64'b0001);
    push("note60 vel0", K_VEL, 0, 64'h64);
    push("note60 ph0 start", K_PH, 0, 64'h0);
    ticks(3);
    push("note60 ph0 after 3 ticks", K_PH, 0, top16(3 * inc_of(60)));

    // Fill all voices, then steal the oldest.
    msg("note62", 24'h903E21, 3);
    msg("note64", 24'h904022, 3);
    msg("note65", 24'h904123, 3);
    push("four voices mask", K_MASK, 0, 64'b1111);
    ticks(20);
    push("v1 after 20 ticks", K_PH, 1, top16(20 * inc_of(62)));
    msg("note67 steal", 24'h904324, 3);
    push("steal vel0", K_VEL, 0, 64'h24);
    push("steal ph0 reset", K_PH, 0, 64'h0);
    push("steal v1 untouched", K_PH, 1, top16(20 * inc_of(62)));
    push("steal mask", K_MASK, 0, 64'b1111);
    msg("vel0 note-off 62", 24'h903E00, 0);
    push("note-off mask", K_MASK, 0, 64'b1101);
    push("note-off ph1", K_PH, 1, 64'h0);

    // Free voice reuse, retrigger, and age-based stealing.
    msg("note60 free", 24'h903C31, 3);
    push("free slot vel1", K_VEL, 1, 64'h31);
    push("free slot mask", K_MASK, 0, 64'b1111);
    ticks(5);
    push("v1 after 5 ticks", K_PH, 1, top16(5 * inc_of(60)));
    msg("note60 retrigger", 24'h903C32, 3);
    push("retrigger vel1", K_VEL, 1, 64'h32);
    push("retrigger ph1 reset", K_PH, 1, 64'h0);
    push("retrigger mask", K_MASK, 0, 64'b1111);
    push("retrigger v0 untouched", K_PH, 0, top16(5 * inc_of(67)));
    msg("note69 steal", 24'h904541, 3);
    push("oldest steal vel2", K_VEL, 2, 64'h41);
    push("oldest steal ph2", K_PH, 2, 64'h0);
    push("oldest steal vel3 kept", K_VEL, 3, 64'h23);
    msg("note-off 64 no match", 24'h804000, 0);
    push("no-match mask", K_MASK, 0, 64'b1111);
    msg("note-off 69 status8", 24'h804510, 0);
    push("status8 off mask", K_MASK, 0, 64'b1011);

    // Messages that must be consumed without effect.
    msg("note below range", 24'h901440, 0);
    push("below range mask", K_MASK, 0, 64'b1011);
    msg("status B", 24'hB00740, 0);
    push("status B mask", K_MASK, 0, 64'b1011);
    msg("channel3 note-on", 24'h933C40, 0);
    msg("channel3 note-off", 24'h833C00, 0);
    push("channel3 mask", K_MASK, 0, 64'b1011);
    push("channel3 vel1", K_VEL, 1, 64'h32);

    // Asynchronous reset while a note-on is in RD1.
    midi_word  = 24'h903C40;
    midi_valid = 1'b1;
    @(posedge clock);
    #1 midi_valid = 1'b0;
    @(posedge clock);
    #2 resetn = 1'b0;
    @(negedge clock);
    push("mid reset mask", K_MASK, 0, 64'h0);
    push("mid reset phase_bus", K_PBUS, 0, 64'h0);
    push("mid reset velocity_bus", K_VBUS, 0, 64'h0);
    push("mid reset ready", K_READY, 0, 64'h1);
    #3 resetn = 1'b1;
    @(negedge clock);
    msg("post-reset note60", 24'h903C50, 3);
    push("post-reset mask", K_MASK, 0, 64'b0001);
    push("post-reset velocity_bus", K_VBUS, 0, 64'h50);

    // Pitch bend sweep and stored bend applied to later notes.
    b1 = bent_of(60, 63);
    b2 = bent_of(60, -64);
    msg("bend 7F", 24'hE0007F, 4);
    ticks(100);
    push("bend up ph0", K_PH, 0, top16(100 * b1));
    msg("bend 00", 24'hE00000, 4);
    ticks(100);
    push("bend down ph0", K_PH, 0, top16(100 * (b1 + b2)));
    msg("note62 bent", 24'h903E51, 3);
    ticks(100);
    push("stored bend ph1", K_PH, 1, top16(100 * bent_of(62, -64)));
    push("stored bend ph0", K_PH, 0, top16(100 * (b1 + 2 * b2)));
    msg("note116 top", 24'h907452, 3);
    ticks(100);
    push("top note ph2", K_PH, 2, top16(100 * bent_of(116, -64)));
    push("final mask", K_MASK, 0, 64'b0111);

    @(negedge clock);
    @(negedge clock);
    #2;
    check("end mask", 64'(active_mask), 64'b0111);
    check("end ready", 64'(midi_ready), 64'h1);
    check("end ph2", 64'(phase_bus[16*2 +: 16]), top16(100 * bent_of(116, -64)));
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
